// File: rtl/hazard_pkg.sv
// Shared types and encodings for the ID/EX hazard controller and its forwarding logic.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A producer can only feed a consumer if it really writes a non-x0 register.
  function automatic logic dest_match(input logic reg_write, input logic [4:0] rd,
                                      input logic [4:0] rs);
    return reg_write && (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_unit_forwarding_unit.sv
// Combinational EX-operand bypass select; EX/MEM results are newer than MEM/WB and win.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       exmem_reg_write,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_reg_write,
  input  logic [4:0] memwb_rd,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  always_comb begin
    forward_a = FWD_REG;
    if (dest_match(exmem_reg_write, exmem_rd, rs1))
      forward_a = FWD_EXMEM;
    else if (dest_match(memwb_reg_write, memwb_rd, rs1))
      forward_a = FWD_MEMWB;
  end

  always_comb begin
    forward_b = FWD_REG;
    if (dest_match(exmem_reg_write, exmem_rd, rs2))
      forward_b = FWD_EXMEM;
    else if (dest_match(memwb_reg_write, memwb_rd, rs2))
      forward_b = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, EX forwarding
// selects and saturating stall/flush event counters.
//
// state | meaning
// RUN   | normal issue; detects branches and load-use hazards
// STALL | holding PC and IF/ID, bubbling ID/EX for the remaining load-use cycles
// FLUSH | squashing IF/ID and ID/EX for the remaining branch-penalty cycles
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_PENALTY    = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             IFID_Valid,
  input  logic [4:0]       IFID_Rs1,
  input  logic [4:0]       IFID_Rs2,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rd,
  input  logic [4:0]       IDEX_Rs1,
  input  logic [4:0]       IDEX_Rs2,
  input  logic             EXMEM_RegWrite,
  input  logic [4:0]       EXMEM_Rd,
  input  logic             MEMWB_RegWrite,
  input  logic [4:0]       MEMWB_Rd,
  input  logic             Branch_Taken,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [1:0]       Forward_A,
  output logic [1:0]       Forward_B,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_PENALTY - 1);
  localparam bit         STALL_MULTI  = (LOAD_STALL_CYCLES > 1);
  localparam bit         FLUSH_MULTI  = (BRANCH_PENALTY > 1);

  state_t     state, state_next;
  logic [2:0] rem, rem_next;
  logic       lu;
  logic       stall_hit;
  logic [1:0] fwd_a, fwd_b;

  assign lu = IFID_Valid && IDEX_MemRead && (IDEX_Rd != REG_X0) &&
              ((IDEX_Rd == IFID_Rs1) || (IDEX_Rd == IFID_Rs2));

  // Only a fresh hazard seen in RUN counts; a branch in the same cycle squashes it.
  assign stall_hit = (state == RUN) && !Branch_Taken && lu;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  always_comb begin
    state_next = state;
    rem_next   = rem;
    if (Branch_Taken) begin
      state_next = FLUSH_MULTI ? FLUSH : RUN;
      rem_next   = FLUSH_MULTI ? FLUSH_RELOAD : 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (lu && STALL_MULTI) begin
            state_next = STALL;
            rem_next   = STALL_RELOAD;
          end
        end
        STALL, FLUSH: begin
          rem_next = rem - 3'd1;
          if (rem == 3'd1)
            state_next = RUN;
        end
        default: begin
          state_next = RUN;
          rem_next   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    if (reset) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (Branch_Taken || (state == FLUSH)) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if ((state == STALL) || lu) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (stall_hit && (Stall_Count != '1))
        Stall_Count <= Stall_Count + CNT_W'(1);
      if (Branch_Taken && (Flush_Count != '1))
        Flush_Count <= Flush_Count + CNT_W'(1);
    end
  end

  forwarding_unit u_forwarding_unit (
    .rs1             (IDEX_Rs1),
    .rs2             (IDEX_Rs2),
    .exmem_reg_write (EXMEM_RegWrite),
    .exmem_rd        (EXMEM_Rd),
    .memwb_reg_write (MEMWB_RegWrite),
    .memwb_rd        (MEMWB_Rd),
    .forward_a       (fwd_a),
    .forward_b       (fwd_b)
  );

  assign Forward_A = reset ? FWD_REG : fwd_a;
  assign Forward_B = reset ? FWD_REG : fwd_b;

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Consumer side of the ID/EX pipeline register in the 5-stage RV64 core.
- Reads decode-stage register indices together with the IDEX_, EXMEM_ and MEMWB_ destination/control fields.
- Drives the PC/IF-ID write enables, the IF/ID and ID/EX flush (bubble) controls, and the EX-stage forwarding selects.
- Holds a small FSM for multi-cycle load-use stalls and branch flush penalties, plus saturating event counters for performance debug.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
BRANCH_PENALTY, 1, cycles IF/ID and ID/EX are flushed after a taken branch (1..7)
CNT_W, 16, width of the stall/flush event counters

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
IFID_Valid  in  1  IF/ID holds a real instruction
IFID_Rs1  in  5  rs1 of the instruction in decode
IFID_Rs2  in  5  rs2 of the instruction in decode
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_Rd  in  5  rd of the instruction in EX
IDEX_Rs1  in  5  rs1 of the instruction in EX
IDEX_Rs2  in  5  rs2 of the instruction in EX
EXMEM_RegWrite  in  1  MEM-stage instruction writes a register
EXMEM_Rd  in  5  MEM-stage rd
MEMWB_RegWrite  in  1  WB-stage instruction writes a register
MEMWB_Rd  in  5  WB-stage rd
Branch_Taken  in  1  taken branch resolved this cycle
PC_Write  out  1  PC load enable
IFID_Write  out  1  IF/ID load enable
IFID_Flush  out  1  zero IF/ID on the next edge
IDEX_Flush  out  1  zero ID/EX control fields on the next edge (bubble)
Forward_A  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
Forward_B  out  2  EX operand B select, same encoding
Stall_Count  out  CNT_W  load-use hazards detected, saturating
Flush_Count  out  CNT_W  taken branches, saturating

Behaviour:
- Interface clocking: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset state:
  - FSM = RUN, down-counter = 0, both event counters = 0.
  - While reset is high: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, Forward_A/B=00.
- Load-use hazard, combinational (`lu`): IFID_Valid && IDEX_MemRead && IDEX_Rd!=0 && (IDEX_Rd==IFID_Rs1 || IDEX_Rd==IFID_Rs2).
- FSM states RUN, STALL, FLUSH; a down-counter `rem` is 3 bits wide.
- RUN:
  - If Branch_Taken: IFID_Flush=1, IDEX_Flush=1, PC_Write=1, Flush_Count+1. If BRANCH_PENALTY>1, go to FLUSH with rem=BRANCH_PENALTY-1.
  - Else if lu: PC_Write=0, IFID_Write=0, IDEX_Flush=1, Stall_Count+1. If LOAD_STALL_CYCLES>1, go to STALL with rem=LOAD_STALL_CYCLES-1.
  - Otherwise all enables are 1 and all flushes are 0.
- STALL:
  - PC_Write=0, IFID_Write=0, IDEX_Flush=1. `lu` is not re-evaluated and is not counted again.
  - rem decrements each cycle; when rem==1, return to RUN.
  - Branch_Taken in STALL: takes the RUN branch action this cycle and transfers to FLUSH per BRANCH_PENALTY. The pending stall is abandoned.
- FLUSH:
  - PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1.
  - rem decrements each cycle; return to RUN when rem==1.
  - A new Branch_Taken in FLUSH reloads rem and counts again.
- Priority: Branch_Taken over load-use. The dependent instruction is on the wrong path and is flushed.
- Forwarding is combinational and state-independent; EX/MEM has priority over MEM/WB.
  - Forward_A = 10 if EXMEM_RegWrite && EXMEM_Rd!=0 && EXMEM_Rd==IDEX_Rs1.
  - Else Forward_A = 01 if MEMWB_RegWrite && MEMWB_Rd!=0 && MEMWB_Rd==IDEX_Rs1.
  - Else Forward_A = 00.
  - Forward_B uses the same rules against IDEX_Rs2.
- Counters increment on the clock edge ending the detecting cycle and saturate at all-ones (no wrap).
- Reset asserted mid-STALL or mid-FLUSH returns immediately (asynchronously) to RUN; counters clear.
- x0 never produces a hazard or a forward.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum RUN/STALL/FLUSH;
  - FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
  - REG_X0=5'd0.
- One natural sub-module, forwarding_unit: a purely combinational Forward_A/B generator, reusable by a later ID-stage branch comparator.
- The FSM and counters stay in the top module.

Test Plan:
- ld x5 in EX (IDEX_MemRead=1, IDEX_Rd=5), decode rs1=5, LOAD_STALL_CYCLES=1 -> PC_Write=0, IFID_Write=0, IDEX_Flush=1 for exactly 1 cycle; Stall_Count 0->1.
- Same hazard with LOAD_STALL_CYCLES=3 -> 3 consecutive stall cycles, then RUN; Stall_Count increments once. IDEX_Rd=0 with rs1=0 -> no stall.
- Branch_Taken=1 and lu=1 in the same cycle, BRANCH_PENALTY=2 -> IFID_Flush=IDEX_Flush=1 for 2 cycles, PC_Write=1 throughout; Flush_Count=1, Stall_Count=0.
- EXMEM_Rd=7 and MEMWB_Rd=7, both RegWrite, IDEX_Rs1=7, IDEX_Rs2=7 -> Forward_A=Forward_B=10. Clear EXMEM_RegWrite -> 01. Set both Rd=0 -> 00.
- Assert reset asynchronously in cycle 2 of a 3-cycle STALL -> outputs take reset values before the next edge; after release, RUN with counters=0.
- CNT_W=4, 20 load-use hazards -> Stall_Count saturates at 15.
